// File: rtl/pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// pipe_stage_elastic
//
// Elastic pipeline-stage register placed between the EXE/MEM/WB stages. It
// carries a control bundle and a data bundle under a valid/ready handshake.
// It has a synchronous flush, an optional skid entry, and a saturating stall
// counter for performance monitoring. A bubble never shows asserted control
// bits downstream.
//
// Parameters
//   DATA_W : payload width (result + store data + wregnum + PC+4)
//   CTRL_W : control width (RegWrite + mem_w + wea + WDSel)
//   SKID   : 1 = two entries, in_ready driven from state only
//            0 = one entry, in_ready passes out_ready through combinationally
//   CNT_W  : stall counter width
//
// Ports
//   clk, rst_n         : clock and asynchronous active-low reset
//   flush              : synchronous kill of all held entries
//   in_valid/in_ready  : upstream handshake
//   in_ctrl/in_data    : upstream control and payload
//   out_valid/out_ready: downstream handshake
//   out_ctrl/out_data  : head control (zero when out_valid=0) and head payload
//   occupancy          : number of held entries (0..2)
//   stall_cnt          : saturating count of cycles with out_valid & !out_ready
// -----------------------------------------------------------------------------
module pipe_stage_elastic #(
    parameter int DATA_W = 101,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Each encoding equals the number of held entries, so occupancy is the
    // state register itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CTRL_W-1:0]  main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0]  main_data_q, main_data_d;
    logic [CTRL_W-1:0]  skid_ctrl_q, skid_ctrl_d;
    logic [DATA_W-1:0]  skid_data_q, skid_data_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic push;
    logic pop;

    assign out_valid = (state_q != EMPTY);

    generate
        if (SKID != 0) begin : g_skid
            // Ready depends on state only, so out_ready has no combinational
            // path to in_ready.
            assign in_ready = (state_q != FULL);
        end else begin : g_pass
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // NOTE: every variable gets a default at the top of always_comb. A path
    // that leaves a variable unassigned would infer a latch.
    always_comb begin
        state_d     = state_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        stall_cnt_d = stall_cnt_q;

        // The counter keeps running through a flush. Only rst_n clears it.
        if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end

        if (flush) begin
            // A pop in this cycle has already been taken downstream. A push
            // in this cycle is dropped.
            state_d     = EMPTY;
            main_ctrl_d = '0;
            main_data_d = '0;
            skid_ctrl_d = '0;
            skid_data_d = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d     = ONE;
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        main_ctrl_d = in_ctrl;
                        main_data_d = in_data;
                    end else if (push && (SKID != 0)) begin
                        // The head is stalled, so park the new entry behind it.
                        state_d     = FULL;
                        skid_ctrl_d = in_ctrl;
                        skid_data_d = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_d     = ONE;
                        main_ctrl_d = skid_ctrl_q;
                        main_data_d = skid_data_q;
                        skid_ctrl_d = '0;
                        skid_data_d = '0;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: the entry registers are few and wide, not a RAM, so they take
    // the async reset. Outputs then read zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_ctrl_q <= '0;
            main_data_q <= '0;
            skid_ctrl_q <= '0;
            skid_data_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register samples its pre-edge value.
            state_q     <= state_d;
            main_ctrl_q <= main_ctrl_d;
            main_data_q <= main_data_d;
            skid_ctrl_q <= skid_ctrl_d;
            skid_data_q <= skid_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Gate control with valid so that a bubble never carries RegWrite/mem_w.
    assign out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign out_data  = main_data_q;
    assign occupancy = state_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_elastic
//
// Directed bench for pipe_stage_elastic. It builds three instances:
//   u_a : default parameters (SKID=1), driven from a vector table
//   u_b : SKID=0, narrow widths, combinational ready pass-through
//   u_c : SKID=1, CNT_W=4, stall counter saturation
// -----------------------------------------------------------------------------
module tb_pipe_stage_elastic;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // ---------------- instance A (defaults) ----------------
    logic         a_fl, a_iv, a_ordy, a_ir, a_ov;
    logic [7:0]   a_ic, a_oc;
    logic [100:0] a_id, a_od;
    logic [1:0]   a_occ;
    logic [15:0]  a_sc;

    pipe_stage_elastic u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_fl),
        .in_valid(a_iv), .in_ready(a_ir), .in_ctrl(a_ic), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_ordy), .out_ctrl(a_oc), .out_data(a_od),
        .occupancy(a_occ), .stall_cnt(a_sc)
    );

    // ---------------- instance B (SKID=0) ----------------
    logic         b_fl, b_iv, b_ordy, b_ir, b_ov;
    logic [7:0]   b_ic, b_oc, b_id, b_od, b_sc;
    logic [1:0]   b_occ;

    pipe_stage_elastic #(.DATA_W(8), .CTRL_W(8), .SKID(0), .CNT_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_fl),
        .in_valid(b_iv), .in_ready(b_ir), .in_ctrl(b_ic), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_ordy), .out_ctrl(b_oc), .out_data(b_od),
        .occupancy(b_occ), .stall_cnt(b_sc)
    );

    // ---------------- instance C (CNT_W=4) ----------------
    logic         c_fl, c_iv, c_ordy, c_ir, c_ov;
    logic [7:0]   c_ic, c_oc, c_id, c_od;
    logic [1:0]   c_occ;
    logic [3:0]   c_sc;

    pipe_stage_elastic #(.DATA_W(8), .CTRL_W(8), .SKID(1), .CNT_W(4)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(c_fl),
        .in_valid(c_iv), .in_ready(c_ir), .in_ctrl(c_ic), .in_data(c_id),
        .out_valid(c_ov), .out_ready(c_ordy), .out_ctrl(c_oc), .out_data(c_od),
        .occupancy(c_occ), .stall_cnt(c_sc)
    );

    // ---------------- vector table for instance A ----------------
    typedef struct {
        logic         fl;
        logic         iv;
        logic [7:0]   ic;
        logic [100:0] id;
        logic         ordy;
        logic         ov;
        logic [7:0]   oc;
        logic [100:0] od;
        logic         chk_od;
        logic         ir;
        logic [1:0]   occ;
        logic [15:0]  sc;
    } vec_t;

    localparam int NV = 17;
    vec_t vt [NV];

    // Distinct 101-bit payload with the top bits set.
    function automatic logic [100:0] dv(input logic [7:0] t);
        return {5'h15, {12{t}}};
    endfunction

    function automatic vec_t mk(
        input logic fl, input logic iv, input logic [7:0] ic,
        input logic [100:0] id, input logic ordy,
        input logic ov, input logic [7:0] oc, input logic [100:0] od,
        input logic chk_od, input logic ir, input logic [1:0] occ,
        input logic [15:0] sc);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy;
        v.ov = ov; v.oc = oc; v.od = od; v.chk_od = chk_od;
        v.ir = ir; v.occ = occ; v.sc = sc;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Expected values are the outputs after the clock edge that samples
        // each row's inputs.
        //            fl iv  ic     id        ordy ov  oc     od        chk ir occ sc
        vt[0]  = mk(0, 1, 8'h81, dv(8'hA1), 1,   1, 8'h81, dv(8'hA1), 1,  1, 1, 0);
        vt[1]  = mk(0, 1, 8'h81, dv(8'hB2), 1,   1, 8'h81, dv(8'hB2), 1,  1, 1, 0);
        vt[2]  = mk(0, 1, 8'h81, dv(8'hC3), 1,   1, 8'h81, dv(8'hC3), 1,  1, 1, 0);
        vt[3]  = mk(0, 0, 8'h00, '0,        1,   0, 8'h00, '0,        0,  1, 0, 0);
        vt[4]  = mk(0, 1, 8'h5A, dv(8'hD4), 0,   1, 8'h5A, dv(8'hD4), 1,  1, 1, 0);
        vt[5]  = mk(0, 1, 8'h3C, dv(8'hE5), 0,   1, 8'h5A, dv(8'hD4), 1,  0, 2, 1);
        vt[6]  = mk(0, 1, 8'h11, dv(8'hF6), 0,   1, 8'h5A, dv(8'hD4), 1,  0, 2, 2);
        vt[7]  = mk(0, 0, 8'h00, '0,        1,   1, 8'h3C, dv(8'hE5), 1,  1, 1, 2);
        vt[8]  = mk(0, 0, 8'h00, '0,        1,   0, 8'h00, '0,        0,  1, 0, 2);
        vt[9]  = mk(0, 1, 8'h81, dv(8'h07), 0,   1, 8'h81, dv(8'h07), 1,  1, 1, 2);
        vt[10] = mk(0, 1, 8'h42, dv(8'h08), 0,   1, 8'h81, dv(8'h07), 1,  0, 2, 3);
        vt[11] = mk(1, 1, 8'hFF, dv(8'h09), 0,   0, 8'h00, '0,        1,  1, 0, 4);
        vt[12] = mk(0, 0, 8'h00, '0,        1,   0, 8'h00, '0,        1,  1, 0, 4);
        vt[13] = mk(0, 1, 8'h81, dv(8'h0A), 1,   1, 8'h81, dv(8'h0A), 1,  1, 1, 4);
        vt[14] = mk(1, 1, 8'h81, dv(8'h0B), 1,   0, 8'h00, '0,        1,  1, 0, 4);
        vt[15] = mk(0, 1, 8'h05, dv(8'h0C), 1,   1, 8'h05, dv(8'h0C), 1,  1, 1, 4);
        vt[16] = mk(0, 0, 8'h00, '0,        1,   0, 8'h00, '0,        0,  1, 0, 4);

        rst_n = 1'b0;
        a_fl = 0; a_iv = 0; a_ic = '0; a_id = '0; a_ordy = 1;
        b_fl = 0; b_iv = 0; b_ic = '0; b_id = '0; b_ordy = 1;
        c_fl = 0; c_iv = 0; c_ic = '0; c_id = '0; c_ordy = 1;

        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("rst_a_out_valid", a_ov, 0);
        check("rst_a_out_ctrl", a_oc, 0);
        check("rst_a_out_data", a_od, 0);
        check("rst_a_in_ready", a_ir, 1);
        check("rst_a_occupancy", a_occ, 0);
        check("rst_a_stall_cnt", a_sc, 0);
        check("rst_b_in_ready", b_ir, 1);
        check("rst_c_stall_cnt", c_sc, 0);

        // ---------------- table-driven run on A ----------------
        for (int i = 0; i < NV; i++) begin
            a_fl = vt[i].fl; a_iv = vt[i].iv; a_ic = vt[i].ic;
            a_id = vt[i].id; a_ordy = vt[i].ordy;
            tick();
            check($sformatf("vec%0d_out_valid", i), a_ov, vt[i].ov);
            check($sformatf("vec%0d_out_ctrl", i), a_oc, vt[i].oc);
            if (vt[i].chk_od)
                check($sformatf("vec%0d_out_data", i), a_od, vt[i].od);
            check($sformatf("vec%0d_in_ready", i), a_ir, vt[i].ir);
            check($sformatf("vec%0d_occupancy", i), a_occ, vt[i].occ);
            check($sformatf("vec%0d_stall_cnt", i), a_sc, vt[i].sc);
        end
        a_fl = 0; a_iv = 0; a_ordy = 1;

        // ---------------- SKID=0 pass-through on B ----------------
        b_iv = 1; b_ic = 8'h81; b_id = 8'hA1; b_ordy = 0;
        #1 check("b_ready_empty", b_ir, 1);
        tick();
        check("b_head_a_valid", b_ov, 1);
        check("b_head_a_data", b_od, 8'hA1);
        // The head is stalled, so ready must drop combinationally.
        b_ic = 8'h42; b_id = 8'hB2; b_ordy = 0;
        #1 check("b_ready_stalled", b_ir, 0);
        tick();
        check("b_hold_a_data", b_od, 8'hA1);
        check("b_occ_not_two", b_occ, 1);
        check("b_stall_cnt", b_sc, 1);
        b_ordy = 1;
        #1 check("b_ready_pass", b_ir, 1);
        tick();
        check("b_replace_data", b_od, 8'hB2);
        check("b_replace_ctrl", b_oc, 8'h42);
        check("b_replace_occ", b_occ, 1);
        b_iv = 0;
        tick();
        check("b_drain_valid", b_ov, 0);
        check("b_drain_ctrl", b_oc, 0);

        // ---------------- saturation on C ----------------
        c_iv = 1; c_ic = 8'h81; c_id = 8'h5C; c_ordy = 0;
        tick();
        c_iv = 0;
        repeat (20) tick();
        check("c_stall_sat", c_sc, 15);
        check("c_held_valid", c_ov, 1);
        check("c_held_data", c_od, 8'h5C);
        c_fl = 1;
        tick();
        c_fl = 0;
        check("c_sat_after_flush", c_sc, 15);
        check("c_flush_valid", c_ov, 0);
        check("c_flush_occ", c_occ, 0);

        // ---------------- reset in mid-operation on A ----------------
        a_iv = 1; a_ic = 8'h81; a_id = dv(8'h33); a_ordy = 0;
        tick();
        a_id = dv(8'h44);
        tick();
        check("mid_full_occ", a_occ, 2);
        a_iv = 0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", a_ov, 0);
        check("mid_rst_ctrl", a_oc, 0);
        check("mid_rst_data", a_od, 0);
        check("mid_rst_occ", a_occ, 0);
        check("mid_rst_stall", a_sc, 0);
        check("mid_rst_ready", a_ir, 1);
        rst_n = 1'b1;
        a_ordy = 1;
        tick();
        check("post_rst_valid", a_ov, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
